// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Pointer, occupancy and valid/ready handshake controller for a
//               first-word-fall-through FIFO built on an external two-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
   parameter int DW        = 18,
   parameter int AW        = 7,
   parameter int AFULL_LVL = 2**AW - 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   count,
   output logic          afull,
   output logic          ram_wen,
   output logic [AW-1:0] ram_wr_addr,
   output logic [DW-1:0] ram_wr_data,
   output logic [AW-1:0] ram_rd_addr,
   input  logic [DW-1:0] ram_rd_data
);

   localparam logic [AW:0] c_afull_lvl = (AW+1)'(AFULL_LVL);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   assign in_rdy  = !w_full && !rst;
   assign out_vld = !w_empty && !rst;
   assign w_push  = in_vld && in_rdy;
   assign w_pop   = out_vld && out_rdy;

   assign ram_wen     = w_push;
   assign ram_wr_addr = r_wr_ptr[AW-1:0];
   assign ram_wr_data = in_data;
   assign ram_rd_addr = r_rd_ptr[AW-1:0];
   assign out_data    = ram_rd_data;

   assign count = r_count;
   assign afull = (r_count >= c_afull_lvl);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Pointer, flag and handshake controller for the team's synchronous FIFO. It drives the write port and read address of the two-port RAM, which has a registered write and a combinational read, and consumes that RAM's read data. It presents valid/ready streaming interfaces on both sides, with first-word-fall-through output. Storage lives entirely in the external RAM; this block holds only pointers, occupancy and flags.

## Interface
- DW, 18, data width; must match the RAM.
- AW, 7, RAM address width; FIFO depth is 2**AW.
- AFULL_LVL, 2**AW-4, occupancy at or above which `afull` asserts; legal range 1..2**AW.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock only.
- in_vld  in  1  producer has a word on `in_data`.
- in_rdy  out  1  FIFO can accept; a push occurs when `in_vld & in_rdy` at a rising edge.
- in_data  in  DW  push data.
- out_vld  out  1  head word is valid on `out_data`.
- out_rdy  in  1  consumer accepts; a pop occurs when `out_vld & out_rdy` at a rising edge.
- out_data  out  DW  head word; equals `ram_rd_data`.
- count  out  AW+1  current occupancy, 0..2**AW.
- afull  out  1  `count >= AFULL_LVL`.
- ram_wen  out  1  RAM write enable; equals push.
- ram_wr_addr  out  AW  write pointer, low AW bits.
- ram_wr_data  out  DW  equals `in_data`.
- ram_rd_addr  out  AW  read pointer, low AW bits.
- ram_rd_data  in  DW  combinational RAM read data at `ram_rd_addr`.

## Operation
- State is kept in three registers:
  - `wr_ptr` and `rd_ptr`, each AW+1 bits; the MSB is the wrap bit and the low AW bits are the RAM address.
  - `count`, AW+1 bits.
- Derived flags:
  - Empty: `wr_ptr == rd_ptr`.
  - Full: low bits equal and MSBs differ.
  - `count` is maintained as its own register and must always equal `wr_ptr - rd_ptr` mod 2**(AW+1).
- `in_rdy = !full & !rst`.
- `out_vld = !empty & !rst`.
- `ram_wen = in_vld & in_rdy`.
- Push:
  - The RAM writes `in_data` at `wr_ptr[AW-1:0]`.
  - `wr_ptr` increments and wraps naturally modulo 2**(AW+1).
- Pop: `rd_ptr` increments, with the same wrap rule.
- Occupancy update, one step per edge:
  - push only: `count + 1`.
  - pop only: `count - 1`.
  - both: unchanged.
  - neither: unchanged.
- Boundary conditions:
  - Full: `in_rdy = 0`, so no push occurs. A pop on that cycle frees a slot; `in_rdy` returns to 1 on the next cycle. There is no same-cycle full pass-through.
  - Empty: `out_vld = 0`, so no pop occurs. A push into an empty FIFO is not bypassed to `out_data`.
  - Overflow and underflow cannot occur by construction. The bench asserts that `count` never exceeds 2**AW and never goes below 0.
- `afull` is combinational from the registered `count`.

## Timing
- Reset values, and values held while `rst` is high:
  - `wr_ptr = rd_ptr = 0`, `count = 0`.
  - `in_rdy = 0`, `out_vld = 0`, `afull = 0`, `ram_wen = 0`.
- First edge after `rst` falls: `in_rdy = 1`.
- Reset mid-operation clears all state immediately. RAM contents are left stale and are never presented, because `out_vld = 0` until new pushes arrive.
- Push-to-output latency is 1 cycle. After a push into an empty FIFO at edge N, `out_vld = 1` and `out_data` shows the pushed word after edge N.
- `out_data` updates combinationally after a pop edge to the next word; there is no read-latency bubble, so throughput is 1 word per cycle.
- Full to not-full: `in_rdy` rises the cycle after the pop.
- Empty to not-empty: `out_vld` rises the cycle after the push.
- `afull` follows `count` in the same cycle.

## Test plan
Directed scenarios use AW=2 (depth 4) and AFULL_LVL=3.
- Reset, then idle:
  - `in_rdy = 1`, `out_vld = 0`, `count = 0`, `afull = 0`.
  - No `ram_wen` pulses.
- Push 0x11, 0x22, 0x33, 0x44 back to back, `out_rdy = 0`:
  - `count` steps 1, 2, 3, 4.
  - `afull` rises at count 3.
  - `in_rdy = 0` at count 4.
  - A fifth `in_vld` is held with no write.
- From full, pop continuously:
  - `out_data` reads 0x11, 0x22, 0x33, 0x44 in order.
  - `in_rdy` rises the cycle after the first pop.
  - `out_vld` falls after the fourth pop.
- Continuous simultaneous push/pop across 10 words:
  - `count` stays at 1 after the initial fill.
  - Pointers wrap past address 3 to 0 with the MSB toggling.
  - Data order is preserved, 1 word per cycle.
- Push into empty at edge N: `out_vld = 0` before edge N, and `out_vld = 1` with the correct data after edge N.
- Assert `rst` asynchronously with count = 3:
  - `in_rdy`, `out_vld`, `count` and `afull` drop to 0 immediately, without waiting for a clock edge.
  - After release, pushing 0x55 then popping yields 0x55, not stale data.
